// File: rtl/life_support_ctrl.sv
// life_support_ctrl: per-zone O2, cabin temperature and power-reserve tracking
// with O2-versus-power arbitration and an OK/WARN/CRIT/FATAL alarm machine.
`timescale 1ns/1ps
module life_support_ctrl #(
    parameter int unsigned W        = 8,
    parameter int unsigned ZONES    = 4,
    parameter int unsigned O2_MAX   = 200,
    parameter int unsigned O2_LOW   = 32,
    parameter int unsigned TEMP_MAX = 100,
    parameter int unsigned TEMP_RST = 20,
    parameter int unsigned PWR_RST  = 255,
    parameter int unsigned GRACE    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 tick,
    input  logic [W-1:0]         o2_init,
    input  logic [W-1:0]         temp_init,
    input  logic [W-1:0]         pwr_init,
    input  logic [W-1:0]         temp_set,
    input  logic [1:0]           mode,
    input  logic [ZONES-1:0]     o2sup,
    input  logic [ZONES-1:0]     breach,
    input  logic                 chrg,
    output logic [ZONES*W-1:0]   o2_lvl,
    output logic [W-1:0]         temp_lvl,
    output logic [W-1:0]         pwr_lvl,
    output logic [ZONES-1:0]     zone_low,
    output logic [1:0]           alarm,
    output logic                 fatal
);

    localparam int unsigned GW = $clog2(GRACE + 1);

    localparam logic [W-1:0]  O2_MAX_L    = W'(O2_MAX);
    localparam logic [W-1:0]  O2_LOW_L    = W'(O2_LOW);
    localparam logic [W-1:0]  TEMP_MAX_L  = W'(TEMP_MAX);
    localparam logic [W-1:0]  TEMP_WARN_L = W'(TEMP_MAX - 8);
    localparam logic [W-1:0]  TEMP_RST_L  = W'(TEMP_RST);
    localparam logic [W-1:0]  PWR_RST_L   = W'(PWR_RST);
    localparam logic [W-1:0]  LVL_SAT     = '1;
    localparam logic [GW-1:0] GRACE_LAST  = GW'(GRACE - 1);

    localparam logic [1:0] MODE_NORMAL  = 2'b00;
    localparam logic [1:0] MODE_DEFENSE = 2'b01;
    localparam logic [1:0] MODE_STEALTH = 2'b10;
    localparam logic [1:0] MODE_EMERG   = 2'b11;

    typedef enum logic [1:0] {
        ST_OK    = 2'b00,
        ST_WARN  = 2'b01,
        ST_CRIT  = 2'b10,
        ST_FATAL = 2'b11
    } alarm_e;

    logic [W-1:0]     o2_q [ZONES];
    logic [W-1:0]     o2_d [ZONES];
    logic [W-1:0]     temp_q, temp_d;
    logic [W-1:0]     pwr_q, pwr_d;
    alarm_e           state_q, state_d;
    logic [GW-1:0]    grace_q, grace_d;
    logic             fatal_q, fatal_d;

    logic             pwr_ok_c;
    logic [1:0]       eff_mode_c;
    logic [ZONES-1:0] grant_c;
    logic [W:0]       cost_c;
    logic [ZONES-1:0] zone_low_c;
    logic             any_zero_c;
    logic             crit_c;
    logic             warn_c;

    // Effective mode, O2 grants and the per-tick power cost they imply
    always_comb begin
        pwr_ok_c   = (pwr_q != '0);
        eff_mode_c = pwr_ok_c ? mode : MODE_NORMAL;
        grant_c    = '0;
        cost_c     = '0;
        for (int i = 0; i < ZONES; i++) begin
            grant_c[i] = pwr_ok_c & (o2sup[i] | (mode == MODE_EMERG));
            cost_c     = cost_c + (W+1)'(grant_c[i]);
        end
        if (eff_mode_c == MODE_DEFENSE) begin
            cost_c = cost_c + (W+1)'(2);
        end
    end

    // Next values of the level registers; everything freezes once FATAL
    always_comb begin
        for (int i = 0; i < ZONES; i++) begin
            o2_d[i] = o2_q[i];
        end
        temp_d = temp_q;
        pwr_d  = pwr_q;
        if (state_q != ST_FATAL) begin
            if (load) begin
                for (int i = 0; i < ZONES; i++) begin
                    o2_d[i] = (o2_init > O2_MAX_L) ? O2_MAX_L : o2_init;
                end
                temp_d = temp_init;
                pwr_d  = pwr_init;
            end else if (tick) begin
                for (int i = 0; i < ZONES; i++) begin
                    if (breach[i]) begin
                        o2_d[i] = (o2_q[i] >= W'(4)) ? (o2_q[i] - W'(4)) : '0;
                    end else if (grant_c[i]) begin
                        o2_d[i] = (o2_q[i] >= O2_MAX_L) ? O2_MAX_L : (o2_q[i] + W'(1));
                    end else begin
                        o2_d[i] = (o2_q[i] != '0) ? (o2_q[i] - W'(1)) : '0;
                    end
                end
                if (eff_mode_c == MODE_STEALTH) begin
                    temp_d = (temp_q != LVL_SAT) ? (temp_q + W'(1)) : temp_q;
                end else if (temp_q < temp_set) begin
                    temp_d = temp_q + W'(1);
                end else if (temp_q > temp_set) begin
                    temp_d = temp_q - W'(1);
                end
                if (chrg) begin
                    pwr_d = (pwr_q != LVL_SAT) ? (pwr_q + W'(1)) : pwr_q;
                end else if ({1'b0, pwr_q} >= cost_c) begin
                    pwr_d = pwr_q - W'(cost_c);
                end else begin
                    pwr_d = '0;
                end
            end
        end
    end

    // Level registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ZONES; i++) begin
                o2_q[i] <= O2_MAX_L;
            end
            temp_q <= TEMP_RST_L;
            pwr_q  <= PWR_RST_L;
        end else begin
            for (int i = 0; i < ZONES; i++) begin
                o2_q[i] <= o2_d[i];
            end
            temp_q <= temp_d;
            pwr_q  <= pwr_d;
        end
    end

    // Hazard conditions derived from the registered levels
    always_comb begin
        zone_low_c = '0;
        any_zero_c = 1'b0;
        for (int i = 0; i < ZONES; i++) begin
            zone_low_c[i] = (o2_q[i] < O2_LOW_L);
            any_zero_c    = any_zero_c | (o2_q[i] == '0);
        end
        crit_c = any_zero_c | (temp_q >= TEMP_MAX_L);
        warn_c = (|zone_low_c) | (temp_q >= TEMP_WARN_L);
    end

    // Alarm state and grace counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_OK;
            grace_q <= '0;
            fatal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            grace_q <= grace_d;
            fatal_q <= fatal_d;
        end
    end

    // Alarm next state; a clearing hazard beats the final grace tick
    always_comb begin
        state_d = state_q;
        grace_d = grace_q;
        case (state_q)
            ST_OK, ST_WARN: begin
                grace_d = '0;
                if (crit_c)      state_d = ST_CRIT;
                else if (warn_c) state_d = ST_WARN;
                else             state_d = ST_OK;
            end
            ST_CRIT: begin
                if (!crit_c) begin
                    grace_d = '0;
                    state_d = warn_c ? ST_WARN : ST_OK;
                end else if (load) begin
                    grace_d = '0;
                end else if (tick) begin
                    if (grace_q == GRACE_LAST) begin
                        state_d = ST_FATAL;
                    end else begin
                        grace_d = grace_q + GW'(1);
                    end
                end
            end
            default: begin
                state_d = ST_FATAL;
            end
        endcase
    end

    // Registered fatal flag tracks the FATAL state exactly
    always_comb begin
        fatal_d = (state_d == ST_FATAL);
    end

    // Output mapping
    always_comb begin
        for (int i = 0; i < ZONES; i++) begin
            o2_lvl[i*W +: W] = o2_q[i];
        end
        temp_lvl = temp_q;
        pwr_lvl  = pwr_q;
        zone_low = zone_low_c;
        alarm    = state_q;
        fatal    = fatal_q;
    end

endmodule

// File: tb/tb_life_support_ctrl.sv
// Bench for life_support_ctrl: table of load/tick vectors plus scripted
// multi-cycle sequences, all checked through an expectation queue.
`timescale 1ns/1ps
module tb_life_support_ctrl;

    localparam int unsigned W     = 8;
    localparam int unsigned ZONES = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 load = 1'b0;
    logic                 tick = 1'b0;
    logic [W-1:0]         o2_init = '0;
    logic [W-1:0]         temp_init = '0;
    logic [W-1:0]         pwr_init = '0;
    logic [W-1:0]         temp_set = 8'd20;
    logic [1:0]           mode = 2'd0;
    logic [ZONES-1:0]     o2sup = '0;
    logic [ZONES-1:0]     breach = '0;
    logic                 chrg = 1'b0;
    logic [ZONES*W-1:0]   o2_lvl;
    logic [W-1:0]         temp_lvl;
    logic [W-1:0]         pwr_lvl;
    logic [ZONES-1:0]     zone_low;
    logic [1:0]           alarm;
    logic                 fatal;

    life_support_ctrl dut (
        .clk(clk), .rst(rst), .load(load), .tick(tick),
        .o2_init(o2_init), .temp_init(temp_init), .pwr_init(pwr_init),
        .temp_set(temp_set), .mode(mode), .o2sup(o2sup), .breach(breach),
        .chrg(chrg), .o2_lvl(o2_lvl), .temp_lvl(temp_lvl), .pwr_lvl(pwr_lvl),
        .zone_low(zone_low), .alarm(alarm), .fatal(fatal)
    );

    always #5 clk = ~clk;

    // Selectors: 0..3 zone O2, 4 temp, 5 pwr, 6 alarm, 7 fatal, 8 zone_low, 9 full o2_lvl
    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    typedef struct {
        logic [7:0] o2i, ti, pi, tset;
        logic [1:0] md;
        logic [3:0] sup, brc;
        logic       chg;
        int         n;
        logic [7:0] e_z0, e_z3, e_t, e_p;
        logic [3:0] e_low;
        logic [1:0] e_al;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[6];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic logic [31:0] actual(int sel);
        case (sel)
            0, 1, 2, 3: actual = 32'(o2_lvl[sel*W +: W]);
            4:          actual = 32'(temp_lvl);
            5:          actual = 32'(pwr_lvl);
            6:          actual = 32'(alarm);
            7:          actual = 32'(fatal);
            8:          actual = 32'(zone_low);
            default:    actual = 32'(o2_lvl);
        endcase
    endfunction

    task automatic expect_v(input string nm, input int sel, input logic [31:0] v);
        exp_t e;
        e.name = nm;
        e.sel  = sel;
        e.exp  = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] a;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            a = actual(e.sel);
            n_cmp++;
            if (a !== e.exp) begin
                n_bad++;
                $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", e.name, a, a, e.exp, e.exp);
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] o2i, input logic [7:0] ti, input logic [7:0] pi);
        o2_init   = o2i;
        temp_init = ti;
        pwr_init  = pi;
        load      = 1'b1;
        step();
        load      = 1'b0;
    endtask

    task automatic do_reset();
        load = 1'b0; tick = 1'b0; mode = 2'd0; o2sup = '0; breach = '0;
        chrg = 1'b0; temp_set = 8'd20;
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //         o2i    ti     pi     tset   md    sup      brc      chg  n   z0     z3     t      p      low      al
        vecs[0] = '{8'd100, 8'd50, 8'd100, 8'd50, 2'd0, 4'b0011, 4'b0000, 1'b0, 10, 8'd110, 8'd90,  8'd50,  8'd80,  4'b0000, 2'd0};
        vecs[1] = '{8'd250, 8'd95, 8'd3,   8'd95, 2'd1, 4'b1111, 4'b0000, 1'b0, 3,  8'd198, 8'd198, 8'd95,  8'd0,   4'b0000, 2'd1};
        vecs[2] = '{8'd10,  8'd30, 8'd50,  8'd20, 2'd3, 4'b0000, 4'b1000, 1'b1, 5,  8'd15,  8'd0,   8'd25,  8'd55,  4'b1111, 2'd2};
        vecs[3] = '{8'd60,  8'd250,8'd250, 8'd0,  2'd2, 4'b1111, 4'b0000, 1'b1, 8,  8'd68,  8'd68,  8'd255, 8'd255, 4'b0000, 2'd2};
        vecs[4] = '{8'd200, 8'd20, 8'd255, 8'd20, 2'd0, 4'b0000, 4'b0000, 1'b0, 4,  8'd196, 8'd196, 8'd20,  8'd255, 4'b0000, 2'd0};
        vecs[5] = '{8'd40,  8'd10, 8'd0,   8'd13, 2'd2, 4'b1111, 4'b0001, 1'b0, 6,  8'd16,  8'd34,  8'd13,  8'd0,   4'b0001, 2'd1};

        // Reset then idle
        do_reset();
        repeat (10) step();
        expect_v("rst_o2", 9, 32'hC8C8C8C8);
        expect_v("rst_temp", 4, 32'd20);
        expect_v("rst_pwr", 5, 32'd255);
        expect_v("rst_alarm", 6, 32'd0);
        expect_v("rst_fatal", 7, 32'd0);
        expect_v("rst_low", 8, 32'd0);
        drain();

        // Table-driven load + tick vectors
        for (int v = 0; v < 6; v++) begin
            mode     = vecs[v].md;
            o2sup    = vecs[v].sup;
            breach   = vecs[v].brc;
            chrg     = vecs[v].chg;
            temp_set = vecs[v].tset;
            do_load(vecs[v].o2i, vecs[v].ti, vecs[v].pi);
            expect_v($sformatf("vec%0d_z0", v), 0, 32'(vecs[v].e_z0));
            expect_v($sformatf("vec%0d_z3", v), 3, 32'(vecs[v].e_z3));
            expect_v($sformatf("vec%0d_temp", v), 4, 32'(vecs[v].e_t));
            expect_v($sformatf("vec%0d_pwr", v), 5, 32'(vecs[v].e_p));
            expect_v($sformatf("vec%0d_low", v), 8, 32'(vecs[v].e_low));
            ticks(vecs[v].n);
            drain();
            expect_v($sformatf("vec%0d_alarm", v), 6, 32'(vecs[v].e_al));
            step();
            drain();
        end

        // O2 decay to just below the low threshold; alarm lags one clock
        do_reset();
        expect_v("decay_o2", 9, 32'h1F1F1F1F);
        expect_v("decay_low", 8, 32'hF);
        expect_v("decay_alarm_lag", 6, 32'd0);
        expect_v("decay_pwr", 5, 32'd255);
        ticks(169);
        drain();
        expect_v("decay_alarm_warn", 6, 32'd1);
        step();
        drain();

        // Breach to CRIT, grace expiry to FATAL, FATAL freezes levels
        do_reset();
        breach = 4'b0100;
        expect_v("brc_z2_zero", 2, 32'd0);
        expect_v("brc_alarm_lag", 6, 32'd1);
        ticks(50);
        drain();
        expect_v("brc_alarm_crit", 6, 32'd2);
        step();
        drain();
        expect_v("grace15_alarm", 6, 32'd2);
        expect_v("grace15_fatal", 7, 32'd0);
        ticks(15);
        drain();
        expect_v("grace16_fatal", 7, 32'd1);
        expect_v("grace16_alarm", 6, 32'd3);
        expect_v("grace16_z0", 0, 32'd134);
        ticks(1);
        drain();
        o2_init = 8'd77; temp_init = 8'd50; pwr_init = 8'd9;
        load = 1'b1; tick = 1'b1;
        repeat (3) step();
        load = 1'b0; tick = 1'b0;
        step();
        expect_v("frz_z0", 0, 32'd134);
        expect_v("frz_z2", 2, 32'd0);
        expect_v("frz_temp", 4, 32'd20);
        expect_v("frz_pwr", 5, 32'd255);
        expect_v("frz_fatal", 7, 32'd1);
        expect_v("frz_alarm", 6, 32'd3);
        drain();

        // DEFENSE drains power; grants drop once it reaches zero
        do_reset();
        mode = 2'd1; o2sup = 4'hF;
        do_load(8'd200, 8'd20, 8'd12);
        expect_v("def_pwr6", 5, 32'd6);
        expect_v("def_z0_sat", 0, 32'd200);
        ticks(1);
        drain();
        expect_v("def_pwr0", 5, 32'd0);
        ticks(1);
        drain();
        expect_v("def_pwr_stay0", 5, 32'd0);
        expect_v("def_z0_dec", 0, 32'd199);
        ticks(1);
        drain();
        expect_v("def_z3_dec2", 3, 32'd198);
        ticks(1);
        drain();

        // STEALTH heating into CRIT, then recovery via NORMAL + setpoint
        do_reset();
        mode = 2'd2; o2sup = 4'hF; temp_set = 8'd20;
        do_load(8'd200, 8'd90, 8'd255);
        expect_v("stl_temp100", 4, 32'd100);
        expect_v("stl_alarm_lag", 6, 32'd1);
        ticks(10);
        drain();
        expect_v("stl_alarm_crit", 6, 32'd2);
        step();
        drain();
        mode = 2'd0;
        expect_v("cool_alarm_warn", 6, 32'd1);
        expect_v("cool_temp98", 4, 32'd98);
        ticks(2);
        drain();
        expect_v("cool_temp90", 4, 32'd90);
        expect_v("cool_alarm_ok", 6, 32'd0);
        ticks(8);
        drain();

        // Async reset in CRIT one tick short of FATAL
        do_reset();
        breach = 4'b0100;
        ticks(50);
        step();
        expect_v("prerst_alarm", 6, 32'd2);
        expect_v("prerst_fatal", 7, 32'd0);
        ticks(15);
        drain();
        #2;
        rst = 1'b0;
        breach = '0;
        #1;
        expect_v("midrst_o2", 9, 32'hC8C8C8C8);
        expect_v("midrst_temp", 4, 32'd20);
        expect_v("midrst_pwr", 5, 32'd255);
        expect_v("midrst_alarm", 6, 32'd0);
        expect_v("midrst_fatal", 7, 32'd0);
        expect_v("midrst_low", 8, 32'd0);
        drain();
        step();
        rst = 1'b1;
        step();
        expect_v("postrst_fatal", 7, 32'd0);
        expect_v("postrst_alarm", 6, 32'd0);
        ticks(1);
        step();
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/life_support_ctrl.md
# life_support_ctrl

Multi-zone, parametrised life-support controller for the spaceship command module. Tracks per-zone oxygen, cabin temperature and a shared power reserve, and arbitrates O2 supply against the power budget under four ship modes. A registered alarm state machine escalates OK → WARN → CRIT → FATAL with a grace countdown. It sits beside the shield/power logic and feeds the command-module status bus.

## Interface
- W, 8, width of every level register (O2, temperature, power)
- ZONES, 4, number of independently tracked O2 zones (1..8)
- O2_MAX, 200, O2 saturation ceiling and O2 reset value
- O2_LOW, 32, WARN threshold: zone O2 < O2_LOW
- TEMP_MAX, 100, CRIT threshold: temp ≥ TEMP_MAX; WARN when temp ≥ TEMP_MAX-8
- TEMP_RST, 20, temperature reset value
- PWR_RST, 255, power reset value
- GRACE, 16, ticks spent in CRIT before FATAL
- clk  in  1  system clock, all state changes on rising edge
- rst  in  1  asynchronous, active-low reset
- load  in  1  synchronous preload of all levels from *_init inputs
- tick  in  1  update strobe; levels change only on cycles with tick=1
- o2_init  in  W  preload value for every zone
- temp_init  in  W  preload temperature
- pwr_init  in  W  preload power
- temp_set  in  W  temperature setpoint
- mode  in  2  00 NORMAL, 01 DEFENSE, 10 STEALTH, 11 EMERGENCY
- o2sup  in  ZONES  per-zone O2 supply request
- breach  in  ZONES  per-zone hull breach
- chrg  in  1  charging; power does not drain
- o2_lvl  out  ZONES*W  zone i at bits [i*W +: W]
- temp_lvl  out  W  current temperature
- pwr_lvl  out  W  current power
- zone_low  out  ZONES  zone O2 < O2_LOW (combinational from registers)
- alarm  out  2  00 OK, 01 WARN, 10 CRIT, 11 FATAL
- fatal  out  1  alarm == FATAL

## Operation
- Effective mode: DEFENSE/STEALTH/EMERGENCY degrade to NORMAL when pwr_lvl == 0.
- Grant: grant[i] = pwr_lvl>0 & (o2sup[i] | mode==EMERGENCY).
- Per zone on tick: breach → O2-4 saturating at 0; else grant → O2+1 saturating at O2_MAX; else O2-1 saturating at 0. Breach overrides grant.
- Temperature on tick: STEALTH → +1 saturating at 2^W-1; otherwise step 1 toward temp_set, hold when equal.
- Power on tick: chrg → +1 saturating at 2^W-1; else subtract cost = popcount(grant) + (eff. DEFENSE ? 2 : 0), saturating at 0. Cost uses pre-update grant.
- load (takes priority over tick): all zones ← min(o2_init, O2_MAX), temp ← temp_init, pwr ← pwr_init; grace counter cleared; alarm not changed.
- Alarm FSM evaluated every clock from registered levels:
  - crit_c = any zone O2 == 0 or temp ≥ TEMP_MAX; warn_c = any zone_low or temp ≥ TEMP_MAX-8.
  - OK/WARN/CRIT → CRIT if crit_c, else WARN if warn_c, else OK.
  - In CRIT, grace counter increments on each tick; reaching GRACE → FATAL. Leaving CRIT clears counter.
  - FATAL is sticky: only rst exits it; load does not. In FATAL all level registers freeze (tick and load ignored).

## Timing
- Reset (async assert, sync release implied by design): every zone O2 = O2_MAX, temp = TEMP_RST, pwr = PWR_RST, alarm = OK, grace = 0, fatal = 0, zone_low = 0.
- Level registers update on the edge where tick or load=1; outputs visible the following cycle.
- alarm lags the level causing it by one clock (evaluated on registered values).
- FATAL asserted on the clock after the GRACE-th tick spent in CRIT.
- Simultaneous crit_c clearing and GRACE-th tick: clearing wins (exit to WARN/OK).
- rst mid-operation: immediate return to reset values regardless of FSM state.

## Test plan
- Reset then idle, tick=0 for 10 cycles → o2_lvl all 200, temp 20, pwr 255, alarm OK.
- o2sup=0, no breach, 169 ticks → zone O2 = 31, zone_low=1111, alarm WARN next cycle.
- breach[2]=1 from 200 for 50 ticks → zone2 = 0, alarm CRIT; 16 more ticks → fatal=1; toggle load → levels unchanged, fatal stays 1.
- mode=DEFENSE, o2sup=1111, pwr_init=12 via load, chrg=0: ticks → pwr 12→6→0; after pwr=0 grants drop and O2 begins decrementing.
- mode=STEALTH, temp_init=90: 10 ticks → temp 100, alarm CRIT; set mode NORMAL, temp_set=20 before GRACE → temp falls, alarm WARN then OK.
- In CRIT at 15 ticks, assert rst → all outputs reset values, grace cleared, no FATAL.
